// File: rtl/jtag_pkg.sv
// Shared TAP definitions: dense 4-bit state encodings, IDCODE width and DR-select type.
package jtag_pkg;

  localparam logic [3:0] ST_TEST_LOGIC_RESET = 4'd0;
  localparam logic [3:0] ST_RUN_TEST_IDLE    = 4'd1;
  localparam logic [3:0] ST_SELECT_DR        = 4'd2;
  localparam logic [3:0] ST_CAPTURE_DR       = 4'd3;
  localparam logic [3:0] ST_SHIFT_DR         = 4'd4;
  localparam logic [3:0] ST_EXIT1_DR         = 4'd5;
  localparam logic [3:0] ST_PAUSE_DR         = 4'd6;
  localparam logic [3:0] ST_EXIT2_DR         = 4'd7;
  localparam logic [3:0] ST_UPDATE_DR        = 4'd8;
  localparam logic [3:0] ST_SELECT_IR        = 4'd9;
  localparam logic [3:0] ST_CAPTURE_IR       = 4'd10;
  localparam logic [3:0] ST_SHIFT_IR         = 4'd11;
  localparam logic [3:0] ST_EXIT1_IR         = 4'd12;
  localparam logic [3:0] ST_PAUSE_IR         = 4'd13;
  localparam logic [3:0] ST_EXIT2_IR         = 4'd14;
  localparam logic [3:0] ST_UPDATE_IR        = 4'd15;

  localparam int IDCODE_DR_WIDTH = 32;

  typedef enum logic [1:0] {
    DR_IDCODE = 2'd0,
    DR_BYPASS = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: registered state, next state purely from tms.
// One tck of latency per transition; trst forces TestLogicReset.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output logic [3:0] tap_state
);

  logic [3:0] next_state;

  always_comb begin
    next_state = tap_state;
    case (tap_state)
      ST_TEST_LOGIC_RESET: next_state = tms ? ST_TEST_LOGIC_RESET : ST_RUN_TEST_IDLE;
      ST_RUN_TEST_IDLE:    next_state = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_DR:        next_state = tms ? ST_SELECT_IR        : ST_CAPTURE_DR;
      ST_CAPTURE_DR:       next_state = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_SHIFT_DR:         next_state = tms ? ST_EXIT1_DR         : ST_SHIFT_DR;
      ST_EXIT1_DR:         next_state = tms ? ST_UPDATE_DR        : ST_PAUSE_DR;
      ST_PAUSE_DR:         next_state = tms ? ST_EXIT2_DR         : ST_PAUSE_DR;
      ST_EXIT2_DR:         next_state = tms ? ST_UPDATE_DR        : ST_SHIFT_DR;
      ST_UPDATE_DR:        next_state = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      ST_SELECT_IR:        next_state = tms ? ST_TEST_LOGIC_RESET : ST_CAPTURE_IR;
      ST_CAPTURE_IR:       next_state = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_SHIFT_IR:         next_state = tms ? ST_EXIT1_IR         : ST_SHIFT_IR;
      ST_EXIT1_IR:         next_state = tms ? ST_UPDATE_IR        : ST_PAUSE_IR;
      ST_PAUSE_IR:         next_state = tms ? ST_EXIT2_IR         : ST_PAUSE_IR;
      ST_EXIT2_IR:         next_state = tms ? ST_UPDATE_IR        : ST_SHIFT_IR;
      ST_UPDATE_IR:        next_state = tms ? ST_SELECT_DR        : ST_RUN_TEST_IDLE;
      default:             next_state = ST_TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge tck) begin
    if (trst) tap_state <= ST_TEST_LOGIC_RESET;
    else      tap_state <= next_state;
  end

endmodule

// File: rtl/jtag_tap.sv
// TAP with IR plus IDCODE/BYPASS/USER data registers; tdo is combinational from the shift regs.
// State effects apply on the posedge leaving the state; user_update pulses the cycle after UpdateDr.
module jtag_tap
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH      = 4,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h0000_FAF1,
  parameter int                  USER_DR_WIDTH = 8,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE     = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_USER       = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS     = '1
) (
  input  logic                     tck,
  input  logic                     trst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_oe,
  output logic                     in_reset,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     user_update
);

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

  logic [IR_WIDTH-1:0]        ir_sr;
  logic [IDCODE_DR_WIDTH-1:0] idcode_sr;
  logic                       bypass_sr;
  logic [USER_DR_WIDTH-1:0]   user_sr;
  logic [USER_DR_WIDTH-1:0]   user_next;
  dr_sel_e                    dr_sel;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (tms),
    .tap_state (tap_state)
  );

  assign in_reset = (tap_state == ST_TEST_LOGIC_RESET);

  // Anything that is neither IDCODE nor USER falls back to BYPASS.
  always_comb begin
    dr_sel = DR_BYPASS;
    if      (ir_value == OP_IDCODE) dr_sel = DR_IDCODE;
    else if (ir_value == OP_USER)   dr_sel = DR_USER;
    else if (ir_value == OP_BYPASS) dr_sel = DR_BYPASS;
  end

  generate
    if (USER_DR_WIDTH == 1) begin : g_user_1
      assign user_next = tdi;
    end else begin : g_user_n
      assign user_next = {tdi, user_sr[USER_DR_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge tck) begin
    if (trst) begin
      ir_value    <= OP_IDCODE;
      ir_sr       <= '0;
      idcode_sr   <= '0;
      bypass_sr   <= 1'b0;
      user_sr     <= '0;
      user_dr_out <= '0;
      user_update <= 1'b0;
    end else begin
      user_update <= 1'b0;
      case (tap_state)
        ST_TEST_LOGIC_RESET: ir_value <= OP_IDCODE;
        ST_CAPTURE_IR:       ir_sr    <= IR_CAPTURE;
        ST_SHIFT_IR:         ir_sr    <= {tdi, ir_sr[IR_WIDTH-1:1]};
        ST_UPDATE_IR:        ir_value <= ir_sr;
        ST_CAPTURE_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= IDCODE_VALUE;
            DR_USER:   user_sr   <= user_dr_in;
            default:   bypass_sr <= 1'b0;
          endcase
        end
        ST_SHIFT_DR: begin
          case (dr_sel)
            DR_IDCODE: idcode_sr <= {tdi, idcode_sr[IDCODE_DR_WIDTH-1:1]};
            DR_USER:   user_sr   <= user_next;
            default:   bypass_sr <= tdi;
          endcase
        end
        ST_UPDATE_DR: begin
          if (dr_sel == DR_USER) begin
            user_dr_out <= user_sr;
            user_update <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tdo    = 1'b0;
    tdo_oe = 1'b0;
    if (tap_state == ST_SHIFT_IR) begin
      tdo    = ir_sr[0];
      tdo_oe = 1'b1;
    end else if (tap_state == ST_SHIFT_DR) begin
      tdo_oe = 1'b1;
      case (dr_sel)
        DR_IDCODE: tdo = idcode_sr[0];
        DR_USER:   tdo = user_sr[0];
        default:   tdo = bypass_sr;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap.sv
// Directed bench for jtag_tap: table-driven FSM walk plus hand-written IR/DR transfer sequences.
module tb_jtag_tap;

  logic       tck = 1'b0;
  logic       trst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_oe;
  logic       in_reset;
  logic [3:0] tap_state;
  logic [3:0] ir_value;
  logic [7:0] user_dr_in;
  logic [7:0] user_dr_out;
  logic       user_update;

  int checks   = 0;
  int failures = 0;

  jtag_tap dut (
    .tck         (tck),
    .trst        (trst),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .tdo_oe      (tdo_oe),
    .in_reset    (in_reset),
    .tap_state   (tap_state),
    .ir_value    (ir_value),
    .user_dr_in  (user_dr_in),
    .user_dr_out (user_dr_out),
    .user_update (user_update)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic [3:0] exp_state;
    logic       exp_tdo;
    logic       exp_oe;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, then settle away from the edge.
  task automatic step(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic reset_tap();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
  endtask

  task automatic tlr_to_shift_dr();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic rti_to_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic tlr_to_shift_ir();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From TestLogicReset, load an opcode and finish in RunTestIdle.
  task automatic load_ir(input logic [3:0] op);
    tlr_to_shift_ir();
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] idv;
    logic [3:0]  pat;
    logic [3:0]  pat_exp;
    logic [7:0]  cap;
    logic [7:0]  shin;

    vecs[0]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd6,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 4'd6,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'd7,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'd4,  1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 4'd5,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 4'd8,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 4'd2,  1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 4'd10, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 4'd11, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 4'd12, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 4'd13, 1'b0, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 4'd14, 1'b0, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 4'd1,  1'b0, 1'b0};

    user_dr_in = 8'h3C;
    trst = 1'b1;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    trst = 1'b0;
    chk("rst_state", 32'(tap_state), 32'd0);
    chk("rst_in_reset", 32'(in_reset), 32'd1);
    chk("rst_ir", 32'(ir_value), 32'd1);
    chk("rst_user_out", 32'(user_dr_out), 32'd0);
    chk("rst_update", 32'(user_update), 32'd0);
    chk("rst_oe", 32'(tdo_oe), 32'd0);

    // FSM walk over every state; IR ends up loaded with 0 (undefined opcode).
    for (int i = 0; i < 23; i++) begin
      step(vecs[i].tms, vecs[i].tdi);
      chk($sformatf("walk%0d_state", i), 32'(tap_state), 32'(vecs[i].exp_state));
      chk($sformatf("walk%0d_tdo", i), 32'(tdo), 32'(vecs[i].exp_tdo));
      chk($sformatf("walk%0d_oe", i), 32'(tdo_oe), 32'(vecs[i].exp_oe));
    end
    chk("walk_ir", 32'(ir_value), 32'h0);

    // IDCODE readout, LSB first.
    reset_tap();
    chk("tlr_in_reset", 32'(in_reset), 32'd1);
    tlr_to_shift_dr();
    idv = 32'h0000FAF1;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("idcode_bit%0d", i), 32'(tdo), 32'(idv[i]));
      chk($sformatf("idcode_oe%0d", i), 32'(tdo_oe), 32'd1);
      step(i == 31, 1'b0);
    end
    chk("idcode_exit_state", 32'(tap_state), 32'd5);
    chk("idcode_exit_oe", 32'(tdo_oe), 32'd0);

    // BYPASS via all-ones opcode: one-cycle delay.
    reset_tap();
    load_ir(4'hF);
    chk("bypass_ir", 32'(ir_value), 32'hF);
    rti_to_shift_dr();
    pat = 4'b1101;
    pat_exp = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bypass_tdo%0d", i), 32'(tdo), 32'(pat_exp[i]));
      step(i == 3, pat[i]);
    end

    // USER capture/shift/update.
    reset_tap();
    load_ir(4'h2);
    chk("user_ir", 32'(ir_value), 32'h2);
    rti_to_shift_dr();
    cap = 8'h3C;
    shin = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("user_tdo%0d", i), 32'(tdo), 32'(cap[i]));
      step(i == 7, shin[i]);
    end
    chk("user_upd_exit1", 32'(user_update), 32'd0);
    step(1'b1, 1'b0);
    chk("user_state_upd", 32'(tap_state), 32'd8);
    chk("user_upd_in_update", 32'(user_update), 32'd0);
    chk("user_out_before", 32'(user_dr_out), 32'd0);
    step(1'b0, 1'b0);
    chk("user_upd_pulse", 32'(user_update), 32'd1);
    chk("user_out", 32'(user_dr_out), 32'hA5);
    step(1'b0, 1'b0);
    chk("user_upd_drop", 32'(user_update), 32'd0);
    chk("user_out_hold", 32'(user_dr_out), 32'hA5);

    // Five tms=1 from mid-shift lands in TestLogicReset; user_dr_out untouched.
    reset_tap();
    chk("tlr_user_hold", 32'(user_dr_out), 32'hA5);
    tlr_to_shift_dr();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    reset_tap();
    chk("tms5_state", 32'(tap_state), 32'd0);
    chk("tms5_in_reset", 32'(in_reset), 32'd1);
    chk("tms5_ir", 32'(ir_value), 32'd1);
    chk("tms5_user_out", 32'(user_dr_out), 32'hA5);
    chk("tms5_update", 32'(user_update), 32'd0);

    // trst mid ShiftIr.
    tlr_to_shift_ir();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pre_trst_state", 32'(tap_state), 32'd11);
    trst = 1'b1;
    step(1'b0, 1'b0);
    trst = 1'b0;
    chk("trst_state", 32'(tap_state), 32'd0);
    chk("trst_ir", 32'(ir_value), 32'd1);
    chk("trst_user_out", 32'(user_dr_out), 32'd0);
    chk("trst_oe", 32'(tdo_oe), 32'd0);

    // Undefined opcode 7 behaves as BYPASS.
    load_ir(4'h7);
    chk("undef_ir", 32'(ir_value), 32'h7);
    rti_to_shift_dr();
    pat = 4'b0011;
    pat_exp = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("undef_tdo%0d", i), 32'(tdo), 32'(pat_exp[i]));
      step(i == 2, pat[i]);
    end
    chk("undef_user_out", 32'(user_dr_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
